// File: rtl/ledscan_bcm.sv
// HUB75 scan controller with binary-coded modulation: shifts one bit-plane of
// a row pair while the previously latched plane is being displayed.
module ledscan_bcm #(
    parameter int WIDTH    = 64,
    parameter int ROW_BITS = 5,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               bright,
    input  logic                     enable,
    input  logic [DEPTH-1:0]         r0,
    input  logic [DEPTH-1:0]         g0,
    input  logic [DEPTH-1:0]         b0,
    input  logic [DEPTH-1:0]         r1,
    input  logic [DEPTH-1:0]         g1,
    input  logic [DEPTH-1:0]         b1,
    output logic [$clog2(WIDTH)-1:0] addrx,
    output logic [ROW_BITS-1:0]      addry,
    output logic [ROW_BITS-1:0]      row_addr,
    output logic [2:0]               rgb0,
    output logic [2:0]               rgb1,
    output logic                     sclk,
    output logic                     latch,
    output logic                     blank,
    output logic                     frame
);

    localparam int XW = $clog2(WIDTH);
    localparam int SW = XW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 8 + DEPTH;
    localparam logic [SW-1:0] LAST_SLOT  = SW'(WIDTH);
    localparam logic [XW-1:0] LAST_COL   = XW'(WIDTH - 1);
    localparam logic [PW-1:0] LAST_PLANE = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_SHIFT    = 2'd0,
        ST_WAIT     = 2'd1,
        ST_PREBLANK = 2'd2,
        ST_LATCH    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic                phase_q, phase_d;
    logic [PW-1:0]       plane_q, plane_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       on_time_s;

    logic [XW-1:0]       addrx_q, addrx_d;
    logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
    logic [2:0]          rgb0_q, rgb0_d;
    logic [2:0]          rgb1_q, rgb1_d;
    logic                sclk_q, sclk_d;
    logic                latch_q, latch_d;
    logic                blank_q, blank_d;
    logic                frame_q, frame_d;

    // Display time of the plane being latched; the counter is sized so this never overflows.
    assign on_time_s = (CW'(bright) + CW'(1)) << plane_q;

    // Sequencer: slot/phase walk of the shift engine, display countdown and row/plane advance.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        phase_d    = phase_q;
        plane_d    = plane_q;
        row_d      = row_q;
        row_addr_d = row_addr_q;
        cnt_d      = (cnt_q != '0) ? (cnt_q - CW'(1)) : cnt_q;
        case (state_q)
            ST_SHIFT: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (slot_q == LAST_SLOT) begin
                        slot_d  = '0;
                        state_d = (cnt_d == '0) ? ST_PREBLANK : ST_WAIT;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end else begin
                    slot_d = slot_q;
                end
            end
            ST_WAIT: begin
                if (cnt_d == '0) begin
                    state_d = ST_PREBLANK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PREBLANK: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d    = ST_SHIFT;
                row_addr_d = row_q;
                cnt_d      = on_time_s;
                if (plane_q == LAST_PLANE) begin
                    plane_d = '0;
                    row_d   = row_q + ROW_BITS'(1);
                end else begin
                    plane_d = plane_q + PW'(1);
                    row_d   = row_q;
                end
            end
            default: begin
                state_d = ST_SHIFT;
            end
        endcase
    end

    // Panel-facing outputs are decoded from the next state so they line up with it when registered.
    always_comb begin
        addrx_d = addrx_q;
        rgb0_d  = rgb0_q;
        rgb1_d  = rgb1_q;
        if (state_d == ST_SHIFT) begin
            addrx_d = (slot_d == LAST_SLOT) ? LAST_COL : slot_d[XW-1:0];
        end else begin
            addrx_d = addrx_q;
        end
        if ((state_q == ST_SHIFT) && phase_q) begin
            rgb0_d = {b0[plane_q], g0[plane_q], r0[plane_q]};
            rgb1_d = {b1[plane_q], g1[plane_q], r1[plane_q]};
        end else begin
            rgb0_d = rgb0_q;
            rgb1_d = rgb1_q;
        end
        sclk_d  = (state_d == ST_SHIFT) && phase_d && (slot_d != '0);
        latch_d = (state_d == ST_LATCH);
        frame_d = (state_d == ST_LATCH) && (row_q == '0) && (plane_q == '0);
        blank_d = (cnt_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SHIFT;
            slot_q     <= '0;
            phase_q    <= 1'b0;
            plane_q    <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            addrx_q    <= '0;
            row_addr_q <= '0;
            rgb0_q     <= 3'd0;
            rgb1_q     <= 3'd0;
            sclk_q     <= 1'b0;
            latch_q    <= 1'b0;
            blank_q    <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            phase_q    <= phase_d;
            plane_q    <= plane_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            addrx_q    <= addrx_d;
            row_addr_q <= row_addr_d;
            rgb0_q     <= rgb0_d;
            rgb1_q     <= rgb1_d;
            sclk_q     <= sclk_d;
            latch_q    <= latch_d;
            blank_q    <= blank_d;
            frame_q    <= frame_d;
        end
    end

    assign addrx    = addrx_q;
    assign addry    = row_q;
    assign row_addr = row_addr_q;
    assign rgb0     = rgb0_q;
    assign rgb1     = rgb1_q;
    assign sclk     = sclk_q;
    assign latch    = latch_q;
    // Disabling darkens the panel at once without touching the sequencing.
    assign blank    = blank_q | ~enable;
    assign frame    = frame_q;

endmodule
